// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int BYTE_W               = 8;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit board input; resets to 1 (idle line level).
module sync_ff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_stages;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stages <= '1;
      end else begin
         r_stages <= {r_stages[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames on rxd to a valid/ready byte stream with framing/overrun pulses.
// Define UART_PARITY_EN for 8E1 framing, which adds a PARITY state and the parity_err output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overrun,
`ifdef UART_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);

   localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] SYNC_CNT = 16'(SYNC_STAGES);

   logic              w_rxs;
   state_t            r_state;
   state_t            w_state_next;
   logic [15:0]       r_cnt;
   logic [15:0]       w_cnt_next;
   logic [2:0]        r_idx;
   logic [2:0]        w_idx_next;
   logic [BYTE_W-1:0] r_shift;
   logic [BYTE_W-1:0] w_shift_next;
   logic              w_stop_ok;
   logic              w_stop_bad;
   logic              r_deliver;
   logic              r_frame_err;
   logic              r_overrun;
   logic              r_valid;
   logic [BYTE_W-1:0] r_data;
`ifdef UART_PARITY_EN
   logic              r_par;
   logic              w_par_next;
   logic              w_par_bad;
   logic              r_parity_err;
`endif

   sync_ff #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (rxd),
      .o_q   (w_rxs)
   );

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + 16'd1;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_stop_ok    = 1'b0;
      w_stop_bad   = 1'b0;
`ifdef UART_PARITY_EN
      w_par_next   = r_par;
      w_par_bad    = 1'b0;
`endif
      case (r_state)
         WAIT_IDLE: begin
            // The synchroniser's reset ones must flush out before rxs is trusted as a real idle level.
            w_cnt_next = (r_cnt < SYNC_CNT) ? r_cnt + 16'd1 : r_cnt;
            if (w_rxs && (r_cnt >= SYNC_CNT)) begin
               w_state_next = IDLE;
            end
         end
         IDLE: begin
            w_cnt_next = 16'd0;
            if (!w_rxs) begin
               w_state_next = START;
            end
         end
         START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt_next   = 16'd0;
               w_idx_next   = 3'd0;
               w_state_next = w_rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_next   = 16'd0;
               w_shift_next = {w_rxs, r_shift[BYTE_W-1:1]};
               w_idx_next   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  w_state_next = PARITY;
`else
                  w_state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_next   = 16'd0;
               w_par_next   = w_rxs;
               w_state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_next = 16'd0;
               if (w_rxs) begin
                  // Leaving at mid stop bit lets a following start edge be caught with no idle gap.
                  w_state_next = IDLE;
`ifdef UART_PARITY_EN
                  if (^{r_shift, r_par}) begin
                     w_par_bad = 1'b1;
                  end else begin
                     w_stop_ok = 1'b1;
                  end
`else
                  w_stop_ok = 1'b1;
`endif
               end else begin
                  w_stop_bad   = 1'b1;
                  w_state_next = WAIT_IDLE;
               end
            end
         end
         default: begin
            w_cnt_next   = 16'd0;
            w_state_next = WAIT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= WAIT_IDLE;
         r_cnt       <= 16'd0;
         r_idx       <= 3'd0;
         r_shift     <= '0;
         r_deliver   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_idx       <= w_idx_next;
         r_shift     <= w_shift_next;
         r_deliver   <= w_stop_ok;
         r_frame_err <= w_stop_bad;
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_par        <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_par        <= w_par_next;
         r_parity_err <= w_par_bad;
      end
   end

   assign parity_err = r_parity_err;
`endif

   // A handshake on the delivery edge frees the holding register, so the new byte replaces it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_deliver) begin
            if (!r_valid || rx_ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != IDLE);

endmodule
